dmem_master: RTL and testbench

Initiator side of the data-memory port. Accepts one load or store at a time from the MEM-stage pipeline over a valid/ready handshake. Sequences the single-cycle `MemRead`/`MemWrite` strobes, address and bidirectional `data` bus toward `data_mem`, and returns read data (or an error) over a valid/ready response channel. Sits between the MEM-stage control logic and `data_mem`.

---
 rtl/dmem_master_pkg.sv | 17 +
 rtl/dmem_addr_chk.sv | 15 +
 rtl/dmem_master.sv | 115 +++++++++++
 tb/tb_dmem_master.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_master_pkg.sv
// Shared types for the data-memory initiator: bus word width and FSM state encodings.
package dmem_master_pkg;

  localparam int WORD = 64;

  typedef enum logic [1:0] {
    DMM_IDLE = 2'd0,
    DMM_WR   = 2'd1,
    DMM_RD   = 2'd2,
    DMM_RESP = 2'd3
  } dmm_state_t;

  function automatic logic misaligned(input logic [WORD-1:0] a);
    return a[2:0] != 3'd0;
  endfunction

endpackage

// File: rtl/dmem_addr_chk.sv
// Combinational legality check for a data-memory request: doubleword alignment and range.
module dmem_addr_chk
  import dmem_master_pkg::*;
#(
  parameter int SIZE = 1024
) (
  input  logic [WORD-1:0] addr,
  output logic            err
);

  localparam logic [WORD-4:0] LIMIT = (WORD-3)'(SIZE);

  assign err = misaligned(addr) || (addr[WORD-1:3] >= LIMIT);

endmodule

// File: rtl/dmem_master.sv
// Initiator side of the data-memory port: one load/store at a time, 1-cycle strobes, registered response.
// Optional alignment/range checking is built in when DMEM_MASTER_CHECK_EN is defined.
//
// state     | meaning
// DMM_IDLE  | ready for a request, strobes low, bus released
// DMM_WR    | MemWrite high for one cycle, bus driven with store data
// DMM_RD    | MemRead high for one cycle, bus captured at the closing edge
// DMM_RESP  | rsp_valid high, response held until rsp_ready
module dmem_master
  import dmem_master_pkg::*;
#(
  parameter int SIZE = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [WORD-1:0] req_addr,
  input  logic [WORD-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [WORD-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic            MemRead,
  output logic            MemWrite,
  output logic [WORD-1:0] addr,
  inout  logic [WORD-1:0] data
);

  dmm_state_t      state;
  logic [WORD-1:0] wdata_q;
  logic            chk_err;

`ifdef DMEM_MASTER_CHECK_EN
  dmem_addr_chk #(.SIZE(SIZE)) u_addr_chk (
    .addr (req_addr),
    .err  (chk_err)
  );
`else
  // SIZE only matters when range checking is built in.
  logic unused_size;
  assign unused_size = ^SIZE;
  assign chk_err     = 1'b0;
`endif

  // The bus is driven only while the write strobe is up; reset clears it asynchronously.
  assign data = MemWrite ? wdata_q : {WORD{1'bz}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= DMM_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      MemRead   <= 1'b0;
      MemWrite  <= 1'b0;
      addr      <= '0;
      wdata_q   <= '0;
    end else begin
      case (state)
        DMM_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            rsp_rdata <= '0;
            if (chk_err) begin
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= DMM_RESP;
            end else begin
              rsp_err <= 1'b0;
              addr    <= req_addr;
              wdata_q <= req_wdata;
              if (req_write) begin
                MemWrite <= 1'b1;
                state    <= DMM_WR;
              end else begin
                MemRead <= 1'b1;
                state   <= DMM_RD;
              end
            end
          end
        end
        DMM_WR: begin
          MemWrite  <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= DMM_RESP;
        end
        DMM_RD: begin
          MemRead   <= 1'b0;
          rsp_rdata <= data;
          rsp_valid <= 1'b1;
          state     <= DMM_RESP;
        end
        DMM_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= DMM_IDLE;
          end
        end
        default: begin
          state <= DMM_IDLE;
        end
      endcase
    end
  end

  a_strobe_excl: assert property (@(posedge clk) disable iff (!rst_n) !(MemRead && MemWrite));
  a_wr_one_cyc:  assert property (@(posedge clk) disable iff (!rst_n) MemWrite |=> !MemWrite);
  a_rd_one_cyc:  assert property (@(posedge clk) disable iff (!rst_n) MemRead |=> !MemRead);
  a_ready_idle:  assert property (@(posedge clk) disable iff (!rst_n) req_ready == (state == DMM_IDLE));

endmodule

// File: tb/tb_dmem_master.sv
// Bench for dmem_master with a behavioural data_mem on the shared bus; table vectors plus corner sequences.
module tb_dmem_master;
  import dmem_master_pkg::*;

  localparam int SIZE = 1024;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic            req_write = 1'b0;
  logic [WORD-1:0] req_addr = '0;
  logic [WORD-1:0] req_wdata = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b1;
  logic [WORD-1:0] rsp_rdata;
  logic            rsp_err;
  logic            MemRead;
  logic            MemWrite;
  logic [WORD-1:0] addr;
  wire  [WORD-1:0] data;

  int tests = 0;
  int fails = 0;
  int viol  = 0;

  always #5 clk = ~clk;

  dmem_master #(.SIZE(SIZE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .addr      (addr),
    .data      (data)
  );

  // data_mem: combinational read onto the bus, write at the clock edge, index = addr/8 truncated
  logic [WORD-1:0] mem [0:SIZE-1];
  logic            mem_init = 1'b1;

  assign data = MemRead ? mem[addr[12:3]] : {WORD{1'bz}};

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < SIZE; i++) mem[i] <= '0;
    end else if (MemWrite) begin
      mem[addr[12:3]] <= data;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      viol <= viol + ((MemRead && MemWrite) ? 1 : 0)
                   + ((!MemRead && !MemWrite && data !== {WORD{1'bz}}) ? 1 : 0)
                   + ((MemRead && $isunknown(data)) ? 1 : 0);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Called at a falling edge with the DUT in IDLE; returns at the falling edge after RESP, back in IDLE.
  task automatic do_txn(input logic wr, input logic [63:0] a, input logic [63:0] wd,
                        input logic [63:0] exp_rd, input logic exp_err, input string name);
    int cyc;
    int wcnt;
    int rcnt;
    int abad;
    cyc = 0; wcnt = 0; rcnt = 0; abad = 0;
    check({name, "_ready"}, req_ready, 1'b1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = wd;
    rsp_ready = 1'b1;
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      cyc++;
      wcnt += int'(MemWrite);
      rcnt += int'(MemRead);
      if ((MemWrite || MemRead) && addr !== a) abad++;
    end while (!rsp_valid && cyc < 8);
    check({name, "_latency"}, cyc, exp_err ? 1 : 2);
    check({name, "_strobes"}, {wcnt[7:0], rcnt[7:0]},
          {(wr && !exp_err) ? 8'd1 : 8'd0, (!wr && !exp_err) ? 8'd1 : 8'd0});
    check({name, "_addr"}, abad, 0);
    check({name, "_rdata"}, rsp_rdata, exp_rd);
    check({name, "_err_busy"}, {rsp_err, req_ready}, {exp_err, 1'b0});
    @(negedge clk);
    check({name, "_idle"}, {rsp_valid, req_ready}, 2'b01);
  endtask

  typedef struct {
    logic        wr;
    logic [63:0] a;
    logic [63:0] wd;
    logic [63:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t        vecs[$];
  logic [63:0] ref_mem [0:15];
  logic [63:0] v;
  time         t0;
  int          bp_bad;
  int          seen;

  initial begin
    vecs.push_back('{1'b1, 64'h10,   64'hDEADBEEF_CAFEF00D, 64'h0, 1'b0});
    vecs.push_back('{1'b0, 64'h10,   64'h0, 64'hDEADBEEF_CAFEF00D, 1'b0});
    vecs.push_back('{1'b1, 64'h18,   64'h01234567_89ABCDEF, 64'h0, 1'b0});
    vecs.push_back('{1'b0, 64'h18,   64'h0, 64'h01234567_89ABCDEF, 1'b0});
    vecs.push_back('{1'b1, 64'h1FF8, 64'hA5A5A5A5_5A5A5A5A, 64'h0, 1'b0});
    vecs.push_back('{1'b0, 64'h1FF8, 64'h0, 64'hA5A5A5A5_5A5A5A5A, 1'b0});
    vecs.push_back('{1'b0, 64'h10,   64'h0, 64'hDEADBEEF_CAFEF00D, 1'b0});
`ifdef DMEM_MASTER_CHECK_EN
    vecs.push_back('{1'b0, 64'h13,   64'h0,  64'h0, 1'b1});
    vecs.push_back('{1'b1, 64'h2000, 64'h55, 64'h0, 1'b1});
    vecs.push_back('{1'b1, 64'h0F,   64'h1,  64'h0, 1'b1});
    vecs.push_back('{1'b0, 64'h0,    64'h0,  64'h0, 1'b0});
    vecs.push_back('{1'b0, 64'h08,   64'h0,  64'h0, 1'b0});
`else
    vecs.push_back('{1'b1, 64'h0F,   64'h1,  64'h0, 1'b0});
    vecs.push_back('{1'b0, 64'h08,   64'h0,  64'h1, 1'b0});
    vecs.push_back('{1'b1, 64'h2000, 64'h55, 64'h0, 1'b0});
    vecs.push_back('{1'b0, 64'h0,    64'h0,  64'h55, 1'b0});
    vecs.push_back('{1'b0, 64'h13,   64'h0,  64'hDEADBEEF_CAFEF00D, 1'b0});
`endif

    repeat (2) @(negedge clk);
    mem_init = 1'b0;
    check("reset_ctl", {req_ready, rsp_valid, rsp_err, MemRead, MemWrite}, 5'b10000);
    check("reset_rdata", rsp_rdata, 64'h0);
    check("reset_addr", addr, 64'h0);
    check("reset_bus_z", data === {WORD{1'bz}}, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++)
      do_txn(vecs[i].wr, vecs[i].a, vecs[i].wd, vecs[i].exp_rd, vecs[i].exp_err, $sformatf("vec%0d", i));

`ifdef DMEM_MASTER_CHECK_EN
    check("mem0_untouched", mem[0], 64'h0);
    check("mem1_untouched", mem[1], 64'h0);
`else
    check("mem1_written", mem[1], 64'h1);
    check("mem0_truncated", mem[0], 64'h55);
`endif

    // Backpressure: rsp_ready low for the first 5 RESP cycles
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h18; rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    bp_bad = 0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      if (!(rsp_valid && rsp_rdata === 64'h01234567_89ABCDEF && !rsp_err && !req_ready)) bp_bad++;
    end
    rsp_ready = 1'b1;
    check("bp_stable", bp_bad, 0);
    @(negedge clk);
    check("bp_idle", {rsp_valid, req_ready}, 2'b01);

    // Back-to-back traffic in a 16-entry window, preloaded so the model knows every value
    t0 = $time;
    for (int i = 0; i < 16; i++) begin
      v = {$urandom, $urandom};
      ref_mem[i] = v;
      do_txn(1'b1, 64'(512 + i) << 3, v, 64'h0, 1'b0, $sformatf("pre%0d", i));
    end
    for (int i = 0; i < 24; i++) begin
      int idx;
      idx = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        v = {$urandom, $urandom};
        ref_mem[idx] = v;
        do_txn(1'b1, 64'(512 + idx) << 3, v, 64'h0, 1'b0, $sformatf("rnd%0d", i));
      end else begin
        do_txn(1'b0, 64'(512 + idx) << 3, 64'h0, ref_mem[idx], 1'b0, $sformatf("rnd%0d", i));
      end
    end
    check("throughput", 64'($time - t0), 64'(40 * 30));

    // Reset asserted while the read strobe is up
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h10; rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_rd_active", MemRead, 1'b1);
    #1 rst_n = 1'b0;
    #1 check("rst_immediate", {MemRead, MemWrite, data === {WORD{1'bz}}, rsp_valid, req_ready}, 5'b00101);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("rst_no_rsp", seen, 0);
    check("rst_ready", req_ready, 1'b1);

    check("bus_exclusive", viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
